// File: rtl/demux_1_to_4_frame_pkg.sv
// Shared definitions for demux_1_to_4_frame: default word width, FSM state
// encoding and slot one-hot decode.
package demux_1_to_4_frame_pkg;

  localparam int unsigned WORD_WIDTH_DEFAULT = 16;
  localparam int unsigned NUM_SLOTS          = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [1:0] slot);
    logic [NUM_SLOTS-1:0] oh;
    oh       = '0;
    oh[slot] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_to_4_frame_word_register.sv
// word_register: WORD_WIDTH-wide register with synchronous active-high reset
// and load enable; one instance per frame slot.
module word_register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/demux_1_to_4_frame.sv
// demux_1_to_4_frame: scatters a valid/ready word stream into four slot
// registers and presents the full frame with out_valid/out_ready.
// Optional macro DEMUX_ADDR_EN: in_sel addresses the slot, completion by mask.
module demux_1_to_4_frame
  import demux_1_to_4_frame_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
`ifdef DEMUX_ADDR_EN
  input  logic [1:0]            in_sel,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out1,
  output logic [WORD_WIDTH-1:0] out2,
  output logic [WORD_WIDTH-1:0] out3,
  output logic [WORD_WIDTH-1:0] out4
);

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic                   release_frame;
  logic                   frame_done;
  logic [1:0]             slot;
  logic [NUM_SLOTS-1:0]   wr_en;
  logic [WORD_WIDTH-1:0]  q [NUM_SLOTS];

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= FILL;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      FILL: if (accept && frame_done) state_next = FULL;
      FULL: if (out_ready)            state_next = FILL;
      default:                        state_next = FILL;
    endcase
  end

  // Outputs decode registered state only, so they can never be high together
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      FILL:    in_ready  = 1'b1;
      FULL:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  always_comb begin
    accept        = in_valid && in_ready;
    release_frame = (state == FULL) && out_ready;
  end

`ifdef DEMUX_ADDR_EN
  logic [NUM_SLOTS-1:0] mask;
  logic [NUM_SLOTS-1:0] mask_set;

  // Rewriting a slot leaves mask unchanged, so it cannot complete the frame
  always_comb begin
    slot       = in_sel;
    mask_set   = mask | slot_onehot(in_sel);
    frame_done = (mask_set == '1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      mask <= '0;
    else if (release_frame)
      mask <= '0;
    else if (accept)
      mask <= mask_set;
  end
`else
  logic [1:0] cnt;

  always_comb begin
    slot       = cnt;
    frame_done = (cnt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (release_frame)
      cnt <= '0;
    else if (accept)
      cnt <= cnt + 2'd1;
  end
`endif

  always_comb begin
    wr_en = '0;
    if (accept)
      wr_en = slot_onehot(slot);
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    word_register #(.WIDTH(WORD_WIDTH)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wr_en[i]),
      .d   (in_data),
      .q   (q[i])
    );
  end

  always_comb begin
    out1 = q[0];
    out2 = q[1];
    out3 = q[2];
    out4 = q[3];
  end

endmodule

// File: tb/tb_demux_1_to_4_frame.sv
// Directed self-checking bench for demux_1_to_4_frame (default build, plus the
// addressed-slot scenario when DEMUX_ADDR_EN is defined).
module tb_demux_1_to_4_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out1, out2, out3, out4;
  logic [15:0] outs [4];
  logic [15:0] exp_w [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_1_to_4_frame #(.WORD_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef DEMUX_ADDR_EN
    .in_sel    (in_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4)
  );

  assign outs[0] = out1;
  assign outs[1] = out2;
  assign outs[2] = out3;
  assign outs[3] = out4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_w[i] = '0;
      tests++;
      if (outs[i] !== 16'h0000) begin
        fails++; $display("FAIL reset_out%0d: got %h expected 0000", i + 1, outs[i]);
      end
    end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_in_order();
    logic [15:0] w [4];
    w[0] = 16'h0F50; w[1] = 16'hFF50; w[2] = 16'hAAAA; w[3] = 16'h7FFF;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i]; in_sel = 2'(i);
      tick();
      exp_w[i] = w[i];
      tests++;
      if (outs[i] !== exp_w[i]) begin
        fails++; $display("FAIL in_order_out%0d: got %h expected %h", i + 1, outs[i], exp_w[i]);
      end
      tests++;
      if (out_valid !== (i == 3)) begin
        fails++; $display("FAIL in_order_valid_%0d: got %b expected %b", i, out_valid, (i == 3));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 16'h1234; in_sel = 2'd0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (out1 !== exp_w[0] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold_%0d: got out1=%h v=%b r=%b expected out1=%h v=1 r=0",
                          c, out1, out_valid, in_ready, exp_w[0]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out1 !== exp_w[0]) begin
      fails++; $display("FAIL bp_handshake: got out1=%h v=%b r=%b expected out1=%h v=0 r=1",
                        out1, out_valid, in_ready, exp_w[0]);
    end
    tick();
    exp_w[0] = 16'h1234;
    tests++;
    if (out1 !== 16'h1234) begin fails++; $display("FAIL bp_accept: got %h expected 1234", out1); end
    for (int i = 1; i < 4; i++) begin
      in_data = 16'(i); in_sel = 2'(i);
      tick();
      exp_w[i] = 16'(i);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (outs[i] !== exp_w[i]) begin
        fails++; $display("FAIL bp_frame_out%0d: got %h expected %h", i + 1, outs[i], exp_w[i]);
      end
    end
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_frame_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    logic [15:0] w [4];
    w[0] = 16'hC001; w[1] = 16'hC0DE; w[2] = 16'h8000; w[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0; in_data = 16'hDEAD; in_sel = 2'(3 - i);
      tick();
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (outs[k] !== exp_w[k]) begin
          fails++; $display("FAIL gap_idle_%0d_out%0d: got %h expected %h", i, k + 1, outs[k], exp_w[k]);
        end
      end
      in_valid = 1'b1; in_data = w[i]; in_sel = 2'(i);
      tick();
      exp_w[i] = w[i];
      tests++;
      if (outs[i] !== exp_w[i] || out_valid !== (i == 3)) begin
        fails++; $display("FAIL gap_accept_%0d: got %h v=%b expected %h v=%b",
                          i, outs[i], out_valid, exp_w[i], (i == 3));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w [4];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'hEE00 + 16'(i); in_sel = 2'(i);
      tick();
    end
    rst = 1'b1; in_data = 16'hBAD0; in_sel = 2'd2;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_w[i] = '0;
      tests++;
      if (outs[i] !== 16'h0000) begin
        fails++; $display("FAIL mid_rst_out%0d: got %h expected 0000", i + 1, outs[i]);
      end
    end
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_rst_flags: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i]; in_sel = 2'(i);
      tick();
      exp_w[i] = w[i];
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (outs[i] !== exp_w[i]) begin
        fails++; $display("FAIL mid_rst_frame_out%0d: got %h expected %h", i + 1, outs[i], exp_w[i]);
      end
    end
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_rst_frame_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // in_valid and out_ready held high: a frame completes every 5 cycles
  task automatic test_back_to_back();
    logic exp_v;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      in_data = 16'hB000 + 16'(e);
      in_sel  = 2'((e - 1) % 5);
      tick();
      exp_v = ((e % 5) == 4);
      tests++;
      if (out_valid !== exp_v || in_ready !== !exp_v) begin
        fails++; $display("FAIL b2b_edge%0d: got v=%b r=%b expected v=%b r=%b",
                          e, out_valid, in_ready, exp_v, !exp_v);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (out1 !== 16'hB006 || out4 !== 16'hB009) begin
      fails++; $display("FAIL b2b_data: got out1=%h out4=%h expected out1=B006 out4=B009", out1, out4);
    end
  endtask

`ifdef DEMUX_ADDR_EN
  task automatic test_addr();
    logic [1:0]  sel [5];
    logic [15:0] dat [5];
    sel[0] = 2'd2; dat[0] = 16'hAAAA;
    sel[1] = 2'd0; dat[1] = 16'h1111;
    sel[2] = 2'd2; dat[2] = 16'h5555;
    sel[3] = 2'd3; dat[3] = 16'h3333;
    sel[4] = 2'd1; dat[4] = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = sel[i]; in_data = dat[i];
      tick();
      tests++;
      if (out_valid !== (i == 4)) begin
        fails++; $display("FAIL addr_valid_%0d: got %b expected %b", i, out_valid, (i == 4));
      end
    end
    in_valid = 1'b0;
    tests++;
    if (out1 !== 16'h1111 || out2 !== 16'h2222 || out3 !== 16'h5555 || out4 !== 16'h3333) begin
      fails++; $display("FAIL addr_frame: got %h %h %h %h expected 1111 2222 5555 3333",
                        out1, out2, out3, out4);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef DEMUX_ADDR_EN
    test_addr();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_1_to_4_frame.md
# demux_1_to_4_frame

Sequential 1-to-4 demultiplexer that assembles a frame of four WORD_WIDTH operand words from a single valid/ready input stream into four registered outputs. It presents the complete frame to the CORDIC datapath with an out_valid/out_ready handshake. It is the write-side counterpart of the 4-to-1 selection mux: the mux picks one of four words, this block scatters one stream into four slots.

## Interface
- WORD_WIDTH, default `WORD_WIDTH (16): width of every data word.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WORD_WIDTH  input word.
- in_sel  input  2  target slot, 0→out1 … 3→out4; present only with DEMUX_ADDR_EN.
- out_valid  output  1  out1..out4 hold a complete frame.
- out_ready  input  1  downstream consumes the frame.
- out1, out2, out3, out4  output  WORD_WIDTH each  slot registers.

## Operation
- States: FILL, FULL; 2-bit slot counter; 4-bit written mask (DEMUX_ADDR_EN only).
- Accept = in_valid && in_ready. in_ready = (state == FILL), a combinational decode of registered state only.
- FILL, on accept: write in_data to the slot selected by the counter, then increment the counter. Accepting slot 3 moves the block to FULL.
- FULL: out_valid = 1 and out1..out4 are stable. in_data is ignored. On out_ready: go to FILL with counter = 0.
- The handshake does not clear out1..out4; they keep the last frame until overwritten.
- out_valid and in_ready are never high together.
- in_valid while in FULL is not accepted. The upstream source must hold its word.
- out_ready while in FILL has no effect.
- Reset mid-frame discards partial writes. The counter returns to 0.
- No arithmetic; words pass through bit-exact. There is no sign or width conversion.

## Timing
- Reset values: out1..out4 = 0, out_valid = 0, in_ready = 1 (state FILL), counter = 0, mask = 0.
- A word accepted at edge N appears on its output after edge N.
- Slot 3 accepted at edge N → out_valid = 1 from edge N onward.
- out_ready sampled high at edge M in FULL → out_valid = 0 and in_ready = 1 after edge M.
- Minimum frame period is 5 cycles: 4 accepts plus 1 handshake cycle.
- rst takes priority over every other input at the same edge.

## Configuration
- Macro: DEMUX_ADDR_EN.
- Undefined: slots are filled strictly in order 0,1,2,3 by the counter. The in_sel port is absent.
- Defined: in_sel selects the slot and each accept sets mask[in_sel]. The block enters FULL on the accept that makes mask = 4'b1111.
- Defined: rewriting an already-written slot overwrites it and does not complete the frame.
- Defined: leaving FULL clears the mask to 0.

## Structure
- Shared definitions belong in settings.h: WORD_WIDTH, the state encoding (FILL = 1'b0, FULL = 1'b1) and DEMUX_ADDR_EN.
- Sub-module word_register: WORD_WIDTH register with synchronous active-high reset and load enable. It is instantiated four times, with enables decoded from the slot selection and accept.

## Test plan
- Reset: assert rst for 2 cycles → outputs 0, out_valid = 0, in_ready = 1.
- In-order fill: send 16'h0F50, 16'hFF50, 16'hAAAA, 16'h7FFF back-to-back with out_ready = 0 → out1..out4 equal those words. out_valid rises after the 4th accept, and in_ready stays 0 while in FULL.
- Backpressure: hold in_valid with 16'h1234 during FULL for 3 cycles, then pulse out_ready → no write during FULL. 16'h1234 is accepted into out1 on the cycle after the handshake.
- Gapped input: toggle in_valid every other cycle → frame completes after 4 accepts. Outputs are unchanged on idle cycles.
- Reset mid-frame: reset after 2 accepts → counter = 0 and outputs = 0. The next 4 words form a correct frame.
- DEMUX_ADDR_EN: write slots 2, 0, 2 (16'hAAAA, then 16'h5555), 3, 1 → out_valid only after slot 1 is written. out3 = 16'h5555.
